boot_loader_bridge: RTL and testbench

//  Sits between VerySimpleCPU and blram on the CPU memory port.

---
 rtl/vscpu_pkg.sv | 12 +
 rtl/boot_loader_bridge_if.sv | 24 ++
 rtl/boot_loader_bridge_packer.sv | 38 +++
 rtl/boot_loader_bridge.sv | 95 +++++++++
 tb/tb_boot_loader_bridge.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vscpu_pkg.sv
// Shared definitions for the VerySimpleCPU memory-port boot loader.
// The bridge FSM states and the RAM data width live here.
package vscpu_pkg;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        WRITE   = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_e;
endpackage

// File: rtl/boot_loader_bridge_if.sv
// Loader byte stream, CPU memory port and blram port of the boot loader bridge.
interface boot_loader_bridge_if #(parameter int SIZE = 14) ();
    import vscpu_pkg::*;

    logic              ld_valid;
    logic              ld_ready;
    logic [7:0]        ld_data;
    logic              ld_last;
    logic              cpu_wrEn;
    logic [SIZE-1:0]   cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              ram_we;
    logic [SIZE-1:0]   ram_addr;
    logic [DATA_W-1:0] ram_data;

    modport master (
        output ld_valid, ld_data, ld_last, cpu_wrEn, cpu_addr, cpu_data,
        input  ld_ready, ram_we, ram_addr, ram_data
    );
    modport slave (
        input  ld_valid, ld_data, ld_last, cpu_wrEn, cpu_addr, cpu_data,
        output ld_ready, ram_we, ram_addr, ram_data
    );
endinterface

// File: rtl/boot_loader_bridge_packer.sv
// Packs loader bytes MSB-first into a 32-bit word; a short final word is
// left-aligned with zero low bytes.
module byte_packer
    import vscpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              take,
    input  logic              last,
    input  logic              clear,
    input  logic [7:0]        din,
    output logic [DATA_W-1:0] word,
    output logic              word_full
);
    logic [1:0]        byte_cnt;
    logic [DATA_W-1:0] shifted;

    // Shifting by the missing byte count pushes stale bytes out and pads with zeros.
    always_comb begin
        shifted = {word[23:0], din};
        if (last) shifted = shifted << {2'd3 - byte_cnt, 3'b000};
    end

    assign word_full = take && (last || byte_cnt == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
            word     <= '0;
        end else begin
            if (take) begin
                word     <= shifted;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (clear) byte_cnt <= '0;
        end
    end
endmodule

// File: rtl/boot_loader_bridge.sv
// Holds the CPU in reset while a byte image is streamed into blram, then
// hands the RAM port to the CPU as a transparent pass-through.
module boot_loader_bridge
    import vscpu_pkg::*;
#(
    parameter int              SIZE           = 14,
    parameter logic [SIZE-1:0] START_ADDR     = '0,
    parameter int              RELEASE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    boot_loader_bridge_if.slave  bus,
    input  logic                 reload,
    output logic                 cpu_rst,
    output logic                 load_done,
    output logic                 load_ovf,
    output logic [SIZE-1:0]      word_count
);
    localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

    state_e            state, state_nxt;
    logic              ld_en, last_q, take, word_full;
    logic [SIZE-1:0]   load_addr;
    logic [RW-1:0]     rel_cnt;
    logic [DATA_W-1:0] word;

    // ld_en keeps ld_ready low while reset is asserted even though state is LOAD.
    assign bus.ld_ready = ld_en && (state == LOAD);
    assign take         = bus.ld_valid && bus.ld_ready;
    assign cpu_rst      = (state != RUN);
    assign load_done    = (state == RUN);

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .take      (take),
        .last      (bus.ld_last),
        .clear     (state == WRITE),
        .din       (bus.ld_data),
        .word      (word),
        .word_full (word_full)
    );

    always_comb begin
        state_nxt    = state;
        bus.ram_we   = (state == WRITE);
        bus.ram_addr = load_addr;
        bus.ram_data = word;
        case (state)
            LOAD:    if (word_full) state_nxt = WRITE;
            WRITE:   state_nxt = last_q ? RELEASE : LOAD;
            RELEASE: if (rel_cnt == RW'(RELEASE_CYCLES - 1)) state_nxt = RUN;
            RUN: begin
                // Selected by the registered state, so a reload cycle still passes the CPU write.
                bus.ram_we   = bus.cpu_wrEn;
                bus.ram_addr = bus.cpu_addr;
                bus.ram_data = bus.cpu_data;
                if (reload) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= LOAD;
            ld_en      <= 1'b0;
            last_q     <= 1'b0;
            load_addr  <= START_ADDR;
            word_count <= '0;
            load_ovf   <= 1'b0;
            rel_cnt    <= '0;
        end else begin
            state <= state_nxt;
            ld_en <= 1'b1;
            case (state)
                LOAD: if (take) last_q <= bus.ld_last;
                WRITE: begin
                    load_addr  <= load_addr + 1'b1;
                    word_count <= word_count + 1'b1;
                    rel_cnt    <= '0;
                    if (&load_addr) load_ovf <= 1'b1;
                end
                RELEASE: rel_cnt <= rel_cnt + 1'b1;
                RUN: if (reload) begin
                    load_addr  <= START_ADDR;
                    word_count <= '0;
                    load_ovf   <= 1'b0;
                    last_q     <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_boot_loader_bridge.sv
// Two bridges (different SIZE/START_ADDR) share one stimulus stream; a
// scoreboard of expected RAM writes is checked by a negedge monitor.
module tb_boot_loader_bridge;
    import vscpu_pkg::*;

    localparam int S0 = 14, S1 = 6, ST0 = 0, ST1 = 50, RC = 4;

    typedef logic [7:0] u8_t;
    typedef struct { logic [13:0] addr; logic [31:0] data; bit last; } wr_t;

    logic clk = 1'b0, rst = 1'b0, reload = 1'b0;
    logic ld_valid = 1'b0, ld_last = 1'b0, cpu_we = 1'b0;
    logic [7:0]  ld_data = '0;
    logic [13:0] cpu_addr = '0;
    logic [31:0] cpu_data = '0;
    always #5 clk = ~clk;

    boot_loader_bridge_if #(.SIZE(S0)) b0 ();
    boot_loader_bridge_if #(.SIZE(S1)) b1 ();
    assign b0.ld_valid = ld_valid;  assign b1.ld_valid = ld_valid;
    assign b0.ld_data  = ld_data;   assign b1.ld_data  = ld_data;
    assign b0.ld_last  = ld_last;   assign b1.ld_last  = ld_last;
    assign b0.cpu_wrEn = cpu_we;    assign b1.cpu_wrEn = cpu_we;
    assign b0.cpu_addr = cpu_addr;  assign b1.cpu_addr = cpu_addr[5:0];
    assign b0.cpu_data = cpu_data;  assign b1.cpu_data = cpu_data;

    logic crst0, crst1, done0, done1, ovf0, ovf1;
    logic [S0-1:0] wc0;
    logic [S1-1:0] wc1;

    boot_loader_bridge #(.SIZE(S0), .START_ADDR(ST0), .RELEASE_CYCLES(RC)) u0 (
        .clk(clk), .rst(rst), .bus(b0), .reload(reload), .cpu_rst(crst0),
        .load_done(done0), .load_ovf(ovf0), .word_count(wc0));
    boot_loader_bridge #(.SIZE(S1), .START_ADDR(ST1), .RELEASE_CYCLES(RC)) u1 (
        .clk(clk), .rst(rst), .bus(b1), .reload(reload), .cpu_rst(crst1),
        .load_done(done1), .load_ovf(ovf1), .word_count(wc1));

    logic        we [2], rdy [2], crst [2], done [2], ovf [2];
    logic [13:0] ad [2], wc [2];
    logic [31:0] dt [2];
    assign we[0] = b0.ram_we;    assign we[1] = b1.ram_we;
    assign rdy[0] = b0.ld_ready; assign rdy[1] = b1.ld_ready;
    assign ad[0] = b0.ram_addr;  assign ad[1] = {8'd0, b1.ram_addr};
    assign dt[0] = b0.ram_data;  assign dt[1] = b1.ram_data;
    assign crst[0] = crst0; assign crst[1] = crst1;
    assign done[0] = done0; assign done[1] = done1;
    assign ovf[0] = ovf0;   assign ovf[1] = ovf1;
    assign wc[0] = wc0;     assign wc[1] = {8'd0, wc1};

    int checks = 0, fails = 0;
    wr_t q0[$], q1[$];
    int  relk [2] = '{0, 0};
    int  exp_addr [2], exp_wc [2];
    bit  exp_ovf [2];
    int  sz [2] = '{S0, S1};
    int  st [2] = '{ST0, ST1};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic model_restart();
        for (int i = 0; i < 2; i++) begin
            exp_addr[i] = st[i]; exp_wc[i] = 0; exp_ovf[i] = 1'b0;
        end
    endtask

    task automatic push(input int i, input int addr, input logic [31:0] data, input bit last);
        wr_t e;
        e.addr = 14'(addr); e.data = data; e.last = last;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Loader view: word k goes to (START + k) mod 2^SIZE.
    task automatic push_word(input logic [31:0] w, input bit last);
        for (int i = 0; i < 2; i++) begin
            push(i, exp_addr[i], w, last);
            if (exp_addr[i] == (1 << sz[i]) - 1) exp_ovf[i] = 1'b1;
            exp_addr[i] = (exp_addr[i] + 1) % (1 << sz[i]);
            exp_wc[i]   = (exp_wc[i] + 1) % (1 << sz[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input u8_t b, input bit last);
        int n = 0;
        while ($urandom_range(0, 3) == 0) begin ld_valid = 1'b0; tick(); end
        ld_valid = 1'b1; ld_data = b; ld_last = last;
        cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 14'($urandom); cpu_data = $urandom;
        reload = ($urandom_range(0, 5) == 0);
        while (!rdy[0] && n < 200) begin tick(); n++; end
        if (n >= 200) begin
            checks++; fails++;
            $display("FAIL ld_ready_timeout actual=0 required=1");
        end
        chk("ld_ready_match", rdy[1], rdy[0]);
        tick();
        ld_valid = 1'b0; ld_last = 1'b0; reload = 1'b0;
    endtask

    task automatic load_image(input u8_t img[$]);
        int nw = (img.size() + 3) / 4;
        for (int k = 0; k < nw; k++) begin
            logic [31:0] w = '0;
            for (int j = 0; j < 4; j++)
                if (4 * k + j < img.size()) w |= 32'(img[4 * k + j]) << (24 - 8 * j);
            push_word(w, k == nw - 1);
        end
        foreach (img[b]) send_byte(img[b], b == img.size() - 1);
        cpu_we = 1'b0;
    endtask

    task automatic wait_run(input string nm);
        int n = 0;
        while (!done[0] && n < 500) begin tick(); n++; end
        if (n >= 500) begin
            checks++; fails++;
            $display("FAIL %s_run_timeout actual=0 required=1", nm);
        end
        for (int i = 0; i < 2; i++) begin
            chk({nm, "_done"}, done[i], 1);
            chk({nm, "_word_count"}, wc[i], 32'(exp_wc[i]));
            chk({nm, "_ovf"}, ovf[i], exp_ovf[i]);
        end
    endtask

    task automatic cpu_write(input logic [13:0] a, input logic [31:0] d, input bit with_reload);
        cpu_we = 1'b1; cpu_addr = a; cpu_data = d; reload = with_reload;
        for (int i = 0; i < 2; i++) push(i, a % (1 << sz[i]), d, 1'b0);
        tick();
        cpu_we = 1'b0; reload = 1'b0;
    endtask

    task automatic after_reload();
        model_restart();
        for (int i = 0; i < 2; i++) begin
            chk("reload_cpu_rst", crst[i], 1);
            chk("reload_done", done[i], 0);
            chk("reload_wc", wc[i], 0);
            chk("reload_ovf", ovf[i], 0);
        end
    endtask

    task automatic do_reload();
        reload = 1'b1; tick(); reload = 1'b0;
        after_reload();
    endtask

    wr_t me;
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                if (relk[i] > 1) chk("cpu_rst_hold", crst[i], 1);
                else if (relk[i] == 1) begin
                    chk("cpu_rst_release", crst[i], 0);
                    chk("load_done_rise", done[i], 1);
                end
                if (relk[i] > 0) relk[i]--;
                if (we[i]) begin
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        checks++; fails++;
                        $display("FAIL unexpected_write[%0d] actual addr=%h data=%h required no write", i, ad[i], dt[i]);
                    end else begin
                        if (i == 0) me = q0.pop_front(); else me = q1.pop_front();
                        chk("wr_addr", ad[i], 32'(me.addr));
                        chk("wr_data", dt[i], me.data);
                        if (me.last) relk[i] = RC + 1;
                    end
                end
            end
        end
    end

    initial begin
        u8_t img[$];
        model_restart();
        #12;
        for (int i = 0; i < 2; i++) begin
            chk("rst_cpu_rst", crst[i], 1);
            chk("rst_ram_we", we[i], 0);
            chk("rst_ld_ready", rdy[i], 0);
            chk("rst_ram_addr", ad[i], 32'(st[i]));
            chk("rst_ram_data", dt[i], 0);
            chk("rst_done", done[i], 0);
            chk("rst_wc", wc[i], 0);
        end
        @(negedge clk); rst = 1'b1;
        tick();
        chk("ld_ready_after_rst", rdy[0], 1);

        img = '{8'hB0, 8'h0C, 8'h80, 8'h33};
        load_image(img);
        wait_run("t1");
        for (int k = 0; k < 3; k++) cpu_write(14'($urandom), $urandom, 1'b0);
        cpu_write(14'd4, 32'ha, 1'b1);
        after_reload();

        img = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h02};
        load_image(img);
        wait_run("t2");
        do_reload();

        img = '{8'hAA, 8'hBB};
        load_image(img);
        wait_run("t3");
        do_reload();

        img.delete();
        for (int k = $urandom_range(57, 60); k > 0; k--) img.push_back(u8_t'($urandom));
        load_image(img);
        wait_run("t5");
        do_reload();

        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        cpu_we = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_restart();
        for (int i = 0; i < 2; i++) begin
            chk("midrst_cpu_rst", crst[i], 1);
            chk("midrst_ram_we", we[i], 0);
            chk("midrst_ld_ready", rdy[i], 0);
            chk("midrst_ram_addr", ad[i], 32'(st[i]));
        end
        @(negedge clk); rst = 1'b1;
        tick();
        img.delete();
        for (int k = 0; k < 16; k++) img.push_back(u8_t'($urandom));
        load_image(img);
        wait_run("t6");

        tick(); tick();
        chk("q0_drain", q0.size(), 0);
        chk("q1_drain", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
